// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// Purpose:
//   32 x 32-bit register file with one write port and two read ports,
//   in the style of an RV32 integer register file. x0 is hardwired to zero.
//   Reads are combinational; writes and reset take effect on the rising edge
//   of i_clk.
//
// Ports:
//   i_clk       - clock, all state changes on its rising edge
//   i_rst       - synchronous active-low reset, clears x1..x31
//   i_rd_wren   - write enable for the rd port
//   i_rd_addr   - write destination index (writes to x0 are dropped)
//   i_rd_data   - write data
//   i_rs1_addr  - read port 1 index
//   i_rs2_addr  - read port 2 index
//   o_rs1_data  - contents of register i_rs1_addr
//   o_rs2_data  - contents of register i_rs2_addr
// ---------------------------------------------------------------------------
module regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rd_wren,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);

    // Entry 0 exists only so the array can be indexed directly by a 5-bit
    // address; it is cleared by reset, never written, and masked on read.
    logic [31:0] r_regs [32];

    logic w_wr_hit;

    // A write only lands when enabled and not aimed at x0.
    assign w_wr_hit = i_rd_wren && (i_rd_addr != 5'd0);

    // Reset has priority over a write arriving on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0000_0000;
            end
        end else if (w_wr_hit) begin
            r_regs[i_rd_addr] <= i_rd_data;
        end
    end

    // Zero-latency reads with no write bypass: the new value appears only
    // after the edge that stores it. The x0 mask keeps zero reads clean even
    // before the first reset edge.
    assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'h0000_0000 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'h0000_0000 : r_regs[i_rs2_addr];

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//
// Purpose:
//   Self-checking bench for regfile. Expected read values are pushed to a
//   scoreboard queue when read addresses are driven and popped and compared
//   once the combinational outputs have settled. A small reference array
//   tracks register contents for the randomised section.
// ---------------------------------------------------------------------------
module tb_regfile;

    logic        i_clk;
    logic        i_rst;
    logic        i_rd_wren;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_rd_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } expect_t;

    expect_t     scoreboard[$];
    logic [31:0] model [32];
    int          errors = 0;
    int          checks = 0;

    regfile dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rd_wren  (i_rd_wren),
        .i_rd_addr  (i_rd_addr),
        .i_rd_data  (i_rd_data),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data)
    );

    // 10 time-unit clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive write-port inputs on the falling edge, away from the active edge.
    task automatic applyStimulus(input logic wren, input logic [4:0] rd, input logic [31:0] data);
        @(negedge i_clk);
        i_rd_wren = wren;
        i_rd_addr = rd;
        i_rd_data = data;
    endtask

    // Let one rising edge happen, then step clear of it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Write through the port and mirror the effect in the reference array.
    task automatic doWrite(input logic wren, input logic [4:0] rd, input logic [31:0] data);
        applyStimulus(wren, rd, data);
        tick();
        if (wren && rd != 5'd0) model[rd] = data;
        i_rd_wren = 1'b0;
    endtask

    // One edge with reset asserted; the write port is left as the caller set it.
    task automatic doReset();
        @(negedge i_clk);
        i_rst = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        i_rst = 1'b1;
        i_rd_wren = 1'b0;
    endtask

    // Drive read addresses and queue the values they must produce.
    task automatic readPush(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2);
        expect_t item;
        item.tag = tag;
        item.e1  = e1;
        item.e2  = e2;
        i_rs1_addr = a1;
        i_rs2_addr = a2;
        scoreboard.push_back(item);
    endtask

    // Pop the oldest expectation and compare both read ports against it.
    task automatic checkOutput();
        expect_t item;
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        item = scoreboard.pop_front();
        checks++;
        assert (o_rs1_data === item.e1) else begin
            errors++;
            $error("FAIL %s rs1 observed=%h expected=%h", item.tag, o_rs1_data, item.e1);
        end
        checks++;
        assert (o_rs2_data === item.e2) else begin
            errors++;
            $error("FAIL %s rs2 observed=%h expected=%h", item.tag, o_rs2_data, item.e2);
        end
    endtask

    task automatic readCheck(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
        readPush(tag, a1, a2, e1, e2);
        checkOutput();
    endtask

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] rd;
        logic        we;

        i_rst      = 1'b0;
        i_rd_wren  = 1'b0;
        i_rd_addr  = 5'd0;
        i_rd_data  = 32'h0;
        i_rs1_addr = 5'd0;
        i_rs2_addr = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        $display("[TB] reset");
        doReset();
        readCheck("reset_x1_x2", 5'd1, 5'd2, 32'h0, 32'h0);
        readCheck("reset_x31_x17", 5'd31, 5'd17, 32'h0, 32'h0);

        $display("[TB] directed writes");
        doWrite(1'b1, 5'd5, 32'h1234_5678);
        readCheck("wr_x5", 5'd5, 5'd0, 32'h1234_5678, 32'h0);
        doWrite(1'b1, 5'd10, 32'h8765_4321);
        readCheck("wr_x10", 5'd10, 5'd5, 32'h8765_4321, 32'h1234_5678);
        doWrite(1'b1, 5'd15, 32'hAABB_CCDD);
        doWrite(1'b0, 5'd20, 32'h0);
        readCheck("wren_off", 5'd15, 5'd20, 32'hAABB_CCDD, 32'h0);
        doWrite(1'b1, 5'd0, 32'hFFFF_FFFF);
        readCheck("wr_x0", 5'd0, 5'd0, 32'h0, 32'h0);
        readCheck("same_addr", 5'd10, 5'd10, 32'h8765_4321, 32'h8765_4321);

        $display("[TB] no same-cycle bypass");
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
        readCheck("pre_edge_old", 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678);
        tick();
        model[5] = 32'hDEAD_BEEF;
        i_rd_wren = 1'b0;
        readCheck("post_edge_new", 5'd5, 5'd10, 32'hDEAD_BEEF, 32'h8765_4321);

        $display("[TB] reset pulse between edges");
        @(negedge i_clk);
        i_rst = 1'b0;
        #2;
        i_rst = 1'b1;
        tick();
        readCheck("glitch_ignored", 5'd5, 5'd15, 32'hDEAD_BEEF, 32'hAABB_CCDD);

        $display("[TB] reset with simultaneous write");
        doWrite(1'b1, 5'd10, 32'h8765_4321);
        applyStimulus(1'b1, 5'd7, 32'h0BAD_F00D);
        doReset();
        readCheck("rst_x5_x10", 5'd5, 5'd10, 32'h0, 32'h0);
        readCheck("rst_x7_x15", 5'd7, 5'd15, 32'h0, 32'h0);
        doWrite(1'b1, 5'd7, 32'h5555_AAAA);
        readCheck("post_rst_write", 5'd7, 5'd5, 32'h5555_AAAA, 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 3) != 0);
            ra = 5'($urandom_range(0, 31));
            rd = $urandom();
            doWrite(we, ra, rd);
            ra = 5'($urandom_range(0, 31));
            rb = (n % 5 == 0) ? ra : 5'($urandom_range(0, 31));
            readCheck("random", ra, rb, model[ra], model[rb]);
        end

        $display("[TB] full sweep");
        for (int a = 0; a < 32; a++) begin
            readCheck("sweep", 5'(a), 5'(31 - a), model[a], model[31 - a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
